arb_client_driver: RTL and testbench
====================================

Name: arb_client_driver

Overview:
- Requester-side counterpart to the arbiter. Per port, it accepts a command and raises `request`, then waits for `grant`.
- Once granted, it holds the resource for a commanded number of cycles, then releases it by dropping `request` and pulsing `acknowledge`.
- Checks grant-side protocol on the fly and flags errors.
- Sits between traffic sources (or bench sequences) and the arbiter's request/acknowledge/grant interface.

Parameters:
- PORTS, 4, number of requester ports; must match the arbiter.
- LEN_W, 8, width of the per-command hold length.
- TIMEOUT, 256, cycles in REQ without grant before `timeout_err` sets; 0 disables the check.
- TO_W, 16, width of the wait counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- cmd_valid  in  PORTS  per-port command valid.
- cmd_ready  out  PORTS  per-port command ready.
- cmd_len  in  PORTS*LEN_W  per-port hold length; port i uses bits [i*LEN_W +: LEN_W].
- request  out  PORTS  request to the arbiter, registered.
- acknowledge  out  PORTS  release pulse to the arbiter, registered.
- grant  in  PORTS  one-hot grant from the arbiter.
- grant_valid  in  1  any grant active.
- grant_encoded  in  $clog2(PORTS)  index of the granted port.
- done  out  PORTS  one-cycle pulse per completed command.
- timeout_err  out  PORTS  sticky, per port.
- proto_err  out  1  sticky, global.

Behaviour:
- Reset (rst=0, asynchronous):
  - Every port state is IDLE and all counters are 0.
  - `request`, `acknowledge`, `done`, `timeout_err` and `proto_err` are all 0.
- Each port has an independent FSM: IDLE -> REQ -> BUSY -> ACK -> IDLE.
- `cmd_ready[i]` = (state_i == IDLE), decoded from registered state.
- IDLE:
  - When cmd_valid&cmd_ready: latch `cmd_len` and clear the wait counter.
  - Next state is REQ, so `request[i]`=1 in the cycle after acceptance.
- REQ:
  - `request`=1; the wait counter increments each cycle, saturating.
  - If the wait counter reaches TIMEOUT-1 with no grant (TIMEOUT!=0), `timeout_err[i]` sets.
  - The port keeps requesting after a timeout; it is never abandoned.
  - When `grant[i]`=1 is sampled: go to BUSY and load hold counter = len.
- BUSY:
  - `request` is held at 1; the hold counter decrements.
  - When the counter is 0, go to ACK. Total BUSY time is len+1 cycles (len=0 gives 1 cycle).
- ACK:
  - One cycle with `request[i]`=0, `acknowledge[i]`=1, `done[i]`=1; then IDLE.
  - Works for both arbiter block modes: REQUEST (releases on request drop) and ACKNOWLEDGE (releases on ack).
- Earliest next command: 2 cycles after `done` (IDLE accept, then REQ).
- Protocol checks, all sticky into `proto_err`, evaluated every cycle after reset:
  - (a) `grant` is not zero or one-hot.
  - (b) `grant_valid` != |`grant`.
  - (c) `grant_valid`=1 and `grant_encoded` != index of the set `grant` bit.
  - (d) `grant[i]`=1 while `request[i]` is 0 in both the current and the previous cycle. This allows the one-cycle grant lag after release.
  - (e) `grant[i]` falls while port i is in BUSY.
- Simultaneous events:
  - Grant sampled in the same cycle the timeout fires: `timeout_err` sets and the grant is still taken.
  - Multiple ports may be in REQ at once; each port only reacts to its own grant bit.
- Reset mid-operation:
  - Asserting rst drops `request`/`acknowledge` immediately (asynchronously) and discards the latched command.
  - Sticky errors clear only on reset.

Test Plan:
- Single port 0, cmd_len=3, arbiter grants 1 cycle after request -> `request[0]` high cycle 1; BUSY cycles 3-6; `acknowledge[0]`=`done[0]`=1 in cycle 7; `request[0]` low in cycle 7; no errors.
- Ports 0-3 commanded together, len=0, PRIORITY arbiter with LSB LOW -> `done` order is 0,1,2,3; each port holds grant 1 cycle; `proto_err`=0.
- TIMEOUT=8, grant held off for 20 cycles on port 2 -> `timeout_err[2]` sets after 8 REQ cycles; port 2 still completes when later granted; `done[2]` pulses once.
- Inject `grant`=4'b0011 -> `proto_err` sets and stays set. Separately, inject `grant_encoded`=2 with `grant`=4'b0010 -> `proto_err` sets.
- Drop `grant[1]` during port 1 BUSY (len=5) -> `proto_err`=1. Separately, grant lingering one cycle after ACK -> no error.
- Assert rst while port 3 is in BUSY -> `request[3]`=0 in the same cycle; `cmd_ready[3]`=1 after release; all outputs 0.

Source files
------------

// File: rtl/arb_client_driver.sv
`default_nettype none
// ============================================================================
// Module      : arb_client_driver
// Description : Requester-side driver for the arbiter with on-the-fly checks
//               of the grant-side protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_client_driver #(
    parameter int PORTS   = 4,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS-1:0]         cmd_valid,
    output logic [PORTS-1:0]         cmd_ready,
    input  logic [PORTS*LEN_W-1:0]   cmd_len,
    output logic [PORTS-1:0]         request,
    output logic [PORTS-1:0]         acknowledge,
    input  logic [PORTS-1:0]         grant,
    input  logic                     grant_valid,
    input  logic [$clog2(PORTS)-1:0] grant_encoded,
    output logic [PORTS-1:0]         done,
    output logic [PORTS-1:0]         timeout_err,
    output logic                     proto_err
);

    localparam logic [1:0]       c_ST_IDLE = 2'd0;
    localparam logic [1:0]       c_ST_REQ  = 2'd1;
    localparam logic [1:0]       c_ST_BUSY = 2'd2;
    localparam logic [1:0]       c_ST_ACK  = 2'd3;
    localparam logic             c_TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0]  c_TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [PORTS-1:0] c_ONE     = PORTS'(1);

    logic [PORTS-1:0] w_orphan_grant;
    logic [PORTS-1:0] w_busy_drop;

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
            logic [1:0]       r_state;
            logic [1:0]       w_state_nxt;
            logic [LEN_W-1:0] r_len;
            logic [LEN_W-1:0] r_hold;
            logic [TO_W-1:0]  r_wait;
            logic             r_req;
            logic             r_req_prev;
            logic             r_ack;
            logic             r_to;

            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    c_ST_IDLE: if (cmd_valid[gi])   w_state_nxt = c_ST_REQ;
                    c_ST_REQ:  if (grant[gi])       w_state_nxt = c_ST_BUSY;
                    c_ST_BUSY: if (r_hold == '0)    w_state_nxt = c_ST_ACK;
                    c_ST_ACK:                       w_state_nxt = c_ST_IDLE;
                    default:                        w_state_nxt = c_ST_IDLE;
                endcase
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_state    <= c_ST_IDLE;
                    r_len      <= '0;
                    r_hold     <= '0;
                    r_wait     <= '0;
                    r_req      <= 1'b0;
                    r_req_prev <= 1'b0;
                    r_ack      <= 1'b0;
                    r_to       <= 1'b0;
                end else begin
                    r_state    <= w_state_nxt;
                    r_req_prev <= r_req;
                    // Outputs are registered from the next state so they line up with it.
                    r_req      <= (w_state_nxt == c_ST_REQ) || (w_state_nxt == c_ST_BUSY);
                    r_ack      <= (w_state_nxt == c_ST_ACK);
                    if (r_state == c_ST_IDLE && cmd_valid[gi]) begin
                        r_len  <= cmd_len[gi*LEN_W +: LEN_W];
                        r_wait <= '0;
                    end
                    if (r_state == c_ST_REQ) begin
                        if (r_wait != '1) r_wait <= r_wait + 1'b1;
                        // A grant in the same cycle does not suppress the timeout flag.
                        if (c_TO_EN && r_wait == c_TO_LAST) r_to <= 1'b1;
                        if (grant[gi]) r_hold <= r_len;
                    end
                    if (r_state == c_ST_BUSY && r_hold != '0) r_hold <= r_hold - 1'b1;
                end
            end

            assign cmd_ready[gi]      = (r_state == c_ST_IDLE);
            assign request[gi]        = r_req;
            assign acknowledge[gi]    = r_ack;
            assign done[gi]           = r_ack;
            assign timeout_err[gi]    = r_to;
            // Grant may trail the request drop by one cycle before it counts as orphaned.
            assign w_orphan_grant[gi] = grant[gi] & ~r_req & ~r_req_prev;
            assign w_busy_drop[gi]    = (r_state == c_ST_BUSY) & ~grant[gi];
        end
    endgenerate

    logic w_multi_hot;
    logic w_valid_bad;
    logic w_enc_bad;
    logic w_err;
    logic r_proto_err;

    assign w_multi_hot = |(grant & (grant - c_ONE));
    assign w_valid_bad = grant_valid != (|grant);
    assign w_enc_bad   = grant_valid && (grant != (c_ONE << grant_encoded));
    assign w_err       = w_multi_hot | w_valid_bad | w_enc_bad |
                         (|w_orphan_grant) | (|w_busy_drop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_proto_err <= 1'b0;
        else      r_proto_err <= r_proto_err | w_err;
    end

    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_arb_client_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_client_driver
// Description : Directed, self-checking bench for arb_client_driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_client_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  cmd_valid = '0;
    logic [3:0]  cmd_ready;
    logic [31:0] cmd_len = '0;
    logic [3:0]  request;
    logic [3:0]  acknowledge;
    logic [3:0]  done;
    logic [3:0]  timeout_err;
    logic        proto_err;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_encoded;

    logic [3:0]  man_grant = '0;
    logic        man_gv    = 1'b0;
    logic [1:0]  man_ge    = '0;
    logic        arb_en    = 1'b0;
    logic [3:0]  arb_grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [1:0] enc(input logic [3:0] g);
        enc = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) enc = 2'(i);
    endfunction

    // Fixed-priority arbiter, lowest index wins, holds until the holder drops request.
    always @(posedge clk) begin
        if (!arb_en)                        arb_grant <= '0;
        else if ((arb_grant & request) == 0) arb_grant <= request & (~request + 4'd1);
    end

    assign grant         = arb_en ? arb_grant        : man_grant;
    assign grant_valid   = arb_en ? (|arb_grant)     : man_gv;
    assign grant_encoded = arb_en ? enc(arb_grant)   : man_ge;

    arb_client_driver #(
        .PORTS(4), .LEN_W(8), .TIMEOUT(8), .TO_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .request(request), .acknowledge(acknowledge),
        .grant(grant), .grant_valid(grant_valid), .grant_encoded(grant_encoded),
        .done(done), .timeout_err(timeout_err), .proto_err(proto_err)
    );

    typedef struct {
        logic       rp;
        logic [3:0] cv;
        logic [7:0] len;
        logic [3:0] g;
        logic       gv;
        logic [1:0] ge;
        logic [3:0] req;
        logic [3:0] ack;
        logic [3:0] rdy;
        logic [3:0] to;
        logic       pe;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rp, input logic [3:0] cv, input logic [7:0] len,
                                input logic [3:0] g, input logic gv, input logic [1:0] ge,
                                input logic [3:0] req, input logic [3:0] ack,
                                input logic [3:0] rdy, input logic [3:0] to, input logic pe);
        vec_t v;
        v.rp = rp; v.cv = cv; v.len = len; v.g = g; v.gv = gv; v.ge = ge;
        v.req = req; v.ack = ack; v.rdy = rdy; v.to = to; v.pe = pe;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0; arb_en = 1'b0; cmd_valid = '0; cmd_len = '0;
        man_grant = '0; man_gv = 1'b0; man_ge = '0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_req, exp_to, exp_done;

        //          rp cv       len g        gv    ge  req      ack      rdy      to       pe
        // Single port 0, len 3, grant one cycle after request, lingers through ACK.
        vecs.push_back(mk(1, 4'b0001, 3, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0001, 4'b0000, 4'b1110, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0001, 1, 0, 4'b0001, 4'b0000, 4'b1110, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0001, 1, 0, 4'b0001, 4'b0000, 4'b1110, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0001, 1, 0, 4'b0001, 4'b0000, 4'b1110, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0001, 1, 0, 4'b0001, 4'b0000, 4'b1110, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0001, 1, 0, 4'b0001, 4'b0000, 4'b1110, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0001, 1, 0, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0));
        // Multi-hot grant; error is sticky.
        vecs.push_back(mk(1, 4'b0000, 0, 4'b0011, 1, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1));
        // Encoded index 2 against grant bit 1 while port 1 requests.
        vecs.push_back(mk(1, 4'b0010, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0010, 1, 2, 4'b0010, 4'b0000, 4'b1101, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0010, 1, 1, 4'b0010, 4'b0000, 4'b1101, 4'b0000, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0010, 1, 1, 4'b0000, 4'b0010, 4'b1101, 4'b0000, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1));
        // grant_valid low while a grant bit is set.
        vecs.push_back(mk(1, 4'b0100, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0100, 0, 2, 4'b0100, 4'b0000, 4'b1011, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0100, 1, 2, 4'b0100, 4'b0000, 4'b1011, 4'b0000, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0100, 1, 2, 4'b0000, 4'b0100, 4'b1011, 4'b0000, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1));
        // Grant to a port that never requested.
        vecs.push_back(mk(1, 4'b0000, 0, 4'b1000, 1, 3, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1));
        // Grant dropped during BUSY of port 1 (len 5).
        vecs.push_back(mk(1, 4'b0010, 5, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0010, 1, 1, 4'b0010, 4'b0000, 4'b1101, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0010, 1, 1, 4'b0010, 4'b0000, 4'b1101, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0010, 4'b0000, 4'b1101, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0010, 1, 1, 4'b0010, 4'b0000, 4'b1101, 4'b0000, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rp) reset_dut();
            check($sformatf("v%0d request", i),     request,     vecs[i].req);
            check($sformatf("v%0d acknowledge", i), acknowledge, vecs[i].ack);
            check($sformatf("v%0d done", i),        done,        vecs[i].ack);
            check($sformatf("v%0d cmd_ready", i),   cmd_ready,   vecs[i].rdy);
            check($sformatf("v%0d timeout_err", i), timeout_err, vecs[i].to);
            check($sformatf("v%0d proto_err", i),   {3'b000, proto_err}, {3'b000, vecs[i].pe});
            cmd_valid = vecs[i].cv;
            cmd_len   = {4{vecs[i].len}};
            man_grant = vecs[i].g;
            man_gv    = vecs[i].gv;
            man_ge    = vecs[i].ge;
            step();
        end

        // Port 2 starved for 20 REQ cycles, then granted with len 1.
        reset_dut();
        for (int c = 0; c <= 27; c++) begin
            exp_req  = (c >= 1 && c <= 23) ? 4'b0100 : 4'b0000;
            exp_to   = (c >= 9) ? 4'b0100 : 4'b0000;
            exp_done = (c == 24) ? 4'b0100 : 4'b0000;
            check($sformatf("to c%0d request", c),     request,     exp_req);
            check($sformatf("to c%0d timeout_err", c), timeout_err, exp_to);
            check($sformatf("to c%0d done", c),        done,        exp_done);
            check($sformatf("to c%0d proto_err", c),   {3'b000, proto_err}, 4'b0000);
            cmd_valid = (c == 0) ? 4'b0100 : 4'b0000;
            cmd_len   = {4{8'd1}};
            man_grant = (c >= 21 && c <= 24) ? 4'b0100 : 4'b0000;
            man_gv    = (c >= 21 && c <= 24);
            man_ge    = 2'd2;
            step();
        end

        // All four ports, len 0, behind the priority arbiter.
        reset_dut();
        arb_en    = 1'b1;
        cmd_valid = 4'b1111;
        cmd_len   = '0;
        step();
        cmd_valid = '0;
        for (int c = 1; c <= 16; c++) begin
            exp_done = (c == 4)  ? 4'b0001 :
                       (c == 7)  ? 4'b0010 :
                       (c == 10) ? 4'b0100 :
                       (c == 13) ? 4'b1000 : 4'b0000;
            check($sformatf("prio c%0d done", c), done, exp_done);
            step();
        end
        check("prio proto_err", {3'b000, proto_err}, 4'b0000);
        check("prio timeout_err", timeout_err, 4'b1100);
        check("prio cmd_ready", cmd_ready, 4'b1111);
        arb_en = 1'b0;

        // Asynchronous reset while port 3 is BUSY.
        reset_dut();
        cmd_valid = 4'b1000;
        cmd_len   = {4{8'd5}};
        step();
        cmd_valid = '0;
        man_grant = 4'b1000; man_gv = 1'b1; man_ge = 2'd3;
        step();
        step();
        step();
        check("busy request", request, 4'b1000);
        rst = 1'b0;
        #1;
        check("async request",     request,     4'b0000);
        check("async acknowledge", acknowledge, 4'b0000);
        check("async done",        done,        4'b0000);
        check("async cmd_ready",   cmd_ready,   4'b1111);
        check("async timeout_err", timeout_err, 4'b0000);
        check("async proto_err",   {3'b000, proto_err}, 4'b0000);
        man_grant = '0; man_gv = 1'b0; man_ge = '0;
        step();
        rst = 1'b1;
        step();
        check("post-rst cmd_ready", cmd_ready, 4'b1111);
        check("post-rst request",   request,   4'b0000);
        check("post-rst proto_err", {3'b000, proto_err}, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
